// File: rtl/usq_pkg.sv
// Shared types and constants for the micro-sequencer address stage.
package usq_pkg;

  localparam int unsigned UADDR_W = 14;
  localparam int unsigned BUT_W   = 6;

  typedef logic [UADDR_W-1:0] uaddr_t;

  localparam logic [BUT_W-1:0] BUT_NONE = 6'h00;
  localparam logic [BUT_W-1:0] BUT_RET  = 6'h01;

  localparam uaddr_t TRAP_VEC_DEF = 14'h0010;
  localparam uaddr_t RST_VEC_DEF  = 14'h0000;

  // Sequential target: low bits of the next field OR'd with condition bits
  // for every branch code except "none" and "return".
  function automatic uaddr_t br_target(input uaddr_t           nxt,
                                       input logic [BUT_W-1:0] but,
                                       input logic [BUT_W-1:0] ubr);
    logic [BUT_W-1:0] m;
    m = ((but != BUT_NONE) && (but != BUT_RET)) ? ubr : '0;
    return {nxt[UADDR_W-1:BUT_W], nxt[BUT_W-1:0] | m};
  endfunction

endpackage

// File: rtl/usq_stack.sv
// Circular micro-return stack: push, pop, or replace-top in one edge.
module usq_stack
  import usq_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_en,
  input  logic                         pop_en,
  input  uaddr_t                       push_data,
  output uaddr_t                       top_c,
  output logic [$clog2(STK_DEPTH):0]   depth,
  output logic                         ovf_c,
  output logic                         unf_c
);

  localparam int unsigned PW = $clog2(STK_DEPTH);
  localparam int unsigned DW = PW + 1;

  uaddr_t          mem_q [STK_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [PW-1:0]   top_idx;
  logic [PW-1:0]   wr_idx;
  logic            wr_en;
  logic            empty;
  logic            full;

  assign top_idx = PW'(ptr_q - 1'b1);
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DW'(STK_DEPTH));
  assign top_c   = mem_q[top_idx];
  assign depth   = depth_q;

  // ptr_q is the next free slot; a push on a full stack lands on the oldest entry.
  always_comb begin
    ptr_d   = ptr_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    ovf_c   = 1'b0;
    unf_c   = 1'b0;
    if (pop_en && push_en) begin
      wr_en = 1'b1;
      if (empty) begin
        unf_c   = 1'b1;
        ptr_d   = PW'(ptr_q + 1'b1);
        depth_d = DW'(1);
      end else begin
        wr_idx = top_idx;
      end
    end else if (pop_en) begin
      if (empty) begin
        unf_c = 1'b1;
      end else begin
        ptr_d   = top_idx;
        depth_d = DW'(depth_q - 1'b1);
      end
    end else if (push_en) begin
      wr_en = 1'b1;
      ptr_d = PW'(ptr_q + 1'b1);
      if (full) begin
        ovf_c = 1'b1;
      end else begin
        depth_d = DW'(depth_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      depth_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
    end
  end

  // Entry storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/usq_addr_seq.sv
// Control-store next-address select: trap, stall, return, or branch target,
// with a micro-return stack and sticky stack error flags.
module usq_addr_seq
  import usq_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 8,
  parameter uaddr_t      TRAP_VEC  = TRAP_VEC_DEF,
  parameter uaddr_t      RST_VEC   = RST_VEC_DEF
) (
  input  logic                         m_clk_l,
  input  logic                         init_l,
  input  logic                         stall_h,
  input  logic                         trap_req_h,
  input  logic [13:0]                  cs_next_h,
  input  logic                         cs_jsr_h,
  input  logic [5:0]                   cs_but_h,
  input  logic [5:0]                   ubr_or_h,
  output logic [13:0]                  cs_addr_h,
  output logic                         trap_ack_h,
  output logic [$clog2(STK_DEPTH):0]   ustk_depth_h,
  output logic                         ustk_ovf_h,
  output logic                         ustk_unf_h
);

  uaddr_t cs_addr_q, cs_addr_d;
  logic   trap_ack_q, trap_ack_d;
  logic   ovf_q, ovf_d;
  logic   unf_q, unf_d;

  logic                         push_en;
  logic                         pop_en;
  uaddr_t                       push_data;
  uaddr_t                       stk_top_c;
  logic [$clog2(STK_DEPTH):0]   stk_depth;
  logic                         stk_ovf_c;
  logic                         stk_unf_c;
  uaddr_t                       addr_inc;

  assign addr_inc = UADDR_W'(cs_addr_q + 1'b1);

  usq_stack #(
    .STK_DEPTH (STK_DEPTH)
  ) u_stack (
    .clk       (m_clk_l),
    .rst_n     (init_l),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .push_data (push_data),
    .top_c     (stk_top_c),
    .depth     (stk_depth),
    .ovf_c     (stk_ovf_c),
    .unf_c     (stk_unf_c)
  );

  // Trap saves the aborted address itself so the microinstruction is retried.
  always_comb begin
    cs_addr_d  = cs_addr_q;
    trap_ack_d = 1'b0;
    push_en    = 1'b0;
    pop_en     = 1'b0;
    push_data  = addr_inc;
    if (trap_req_h) begin
      push_en    = 1'b1;
      push_data  = cs_addr_q;
      cs_addr_d  = TRAP_VEC;
      trap_ack_d = 1'b1;
    end else if (stall_h) begin
      cs_addr_d = cs_addr_q;
    end else if (cs_but_h == BUT_RET) begin
      pop_en    = 1'b1;
      push_en   = cs_jsr_h;
      cs_addr_d = (stk_depth == '0) ? RST_VEC : stk_top_c;
    end else begin
      push_en   = cs_jsr_h;
      cs_addr_d = br_target(cs_next_h, cs_but_h, ubr_or_h);
    end
    ovf_d = ovf_q | stk_ovf_c;
    unf_d = unf_q | stk_unf_c;
  end

  always_ff @(posedge m_clk_l or negedge init_l) begin
    if (!init_l) begin
      cs_addr_q  <= RST_VEC;
      trap_ack_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      cs_addr_q  <= cs_addr_d;
      trap_ack_q <= trap_ack_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign cs_addr_h    = cs_addr_q;
  assign trap_ack_h   = trap_ack_q;
  assign ustk_depth_h = stk_depth;
  assign ustk_ovf_h   = ovf_q;
  assign ustk_unf_h   = unf_q;

endmodule

// File: tb/tb_usq_addr_seq.sv
// Bench for usq_addr_seq: directed vector table, hand sequences for
// overflow/underflow and async reset, then random stimulus vs a queue model.
module tb_usq_addr_seq;
  import usq_pkg::*;

  localparam int unsigned D  = 8;
  localparam int unsigned DW = $clog2(D) + 1;

  logic          m_clk_l    = 1'b0;
  logic          init_l     = 1'b0;
  logic          stall_h    = 1'b0;
  logic          trap_req_h = 1'b0;
  logic [13:0]   cs_next_h  = '0;
  logic          cs_jsr_h   = 1'b0;
  logic [5:0]    cs_but_h   = '0;
  logic [5:0]    ubr_or_h   = '0;
  logic [13:0]   cs_addr_h;
  logic          trap_ack_h;
  logic [DW-1:0] ustk_depth_h;
  logic          ustk_ovf_h;
  logic          ustk_unf_h;

  int checks   = 0;
  int failures = 0;

  usq_addr_seq #(
    .STK_DEPTH (D),
    .TRAP_VEC  (14'h0010),
    .RST_VEC   (14'h0000)
  ) dut (
    .m_clk_l      (m_clk_l),
    .init_l       (init_l),
    .stall_h      (stall_h),
    .trap_req_h   (trap_req_h),
    .cs_next_h    (cs_next_h),
    .cs_jsr_h     (cs_jsr_h),
    .cs_but_h     (cs_but_h),
    .ubr_or_h     (ubr_or_h),
    .cs_addr_h    (cs_addr_h),
    .trap_ack_h   (trap_ack_h),
    .ustk_depth_h (ustk_depth_h),
    .ustk_ovf_h   (ustk_ovf_h),
    .ustk_unf_h   (ustk_unf_h)
  );

  always #5 m_clk_l = ~m_clk_l;

  typedef struct {
    logic        trap;
    logic        stall;
    logic        jsr;
    logic [5:0]  but;
    logic [5:0]  ubr;
    logic [13:0] nxt;
    logic [13:0] e_addr;
    logic        e_ack;
    int          e_depth;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the return stack is a plain queue, newest at the back.
  logic [13:0] mq[$];
  logic [13:0] m_addr;
  logic        m_ack;
  logic        m_ovf;
  logic        m_unf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [13:0] a, input logic ack,
                         input int dep, input logic ovf, input logic unf);
    chk({tag, ".addr"},  32'(cs_addr_h),    32'(a));
    chk({tag, ".ack"},   32'(trap_ack_h),   32'(ack));
    chk({tag, ".depth"}, 32'(ustk_depth_h), 32'(dep));
    chk({tag, ".ovf"},   32'(ustk_ovf_h),   32'(ovf));
    chk({tag, ".unf"},   32'(ustk_unf_h),   32'(unf));
  endtask

  task automatic drive(input logic trap, input logic stall, input logic jsr,
                       input logic [5:0] but, input logic [5:0] ubr, input logic [13:0] nxt);
    trap_req_h = trap;
    stall_h    = stall;
    cs_jsr_h   = jsr;
    cs_but_h   = but;
    ubr_or_h   = ubr;
    cs_next_h  = nxt;
  endtask

  task automatic tick();
    @(posedge m_clk_l);
    #1;
  endtask

  // Called just after a sampling point; reset pulse stays clear of clock edges.
  task automatic pulse_reset();
    #2 init_l = 1'b0;
    #2 init_l = 1'b1;
  endtask

  function automatic vec_t mk(input logic trap, input logic stall, input logic jsr,
                              input logic [5:0] but, input logic [5:0] ubr,
                              input logic [13:0] nxt, input logic [13:0] e_addr,
                              input logic e_ack, input int e_depth,
                              input logic e_ovf, input logic e_unf);
    vec_t v;
    v.trap = trap; v.stall = stall; v.jsr = jsr; v.but = but; v.ubr = ubr;
    v.nxt = nxt; v.e_addr = e_addr; v.e_ack = e_ack; v.e_depth = e_depth;
    v.e_ovf = e_ovf; v.e_unf = e_unf;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_addr = 14'h0000;
    m_ack  = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_push(input logic [13:0] v);
    mq.push_back(v);
    if (mq.size() > D) begin
      void'(mq.pop_front());
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [13:0] ret;
    logic [13:0] cur;
    logic [5:0]  m;
    cur = m_addr;
    m_ack = 1'b0;
    if (trap_req_h) begin
      model_push(cur);
      m_addr = 14'h0010;
      m_ack  = 1'b1;
    end else if (stall_h) begin
      m_addr = cur;
    end else if (cs_but_h == 6'h01) begin
      if (mq.size() == 0) begin
        m_unf = 1'b1;
        ret   = 14'h0000;
      end else begin
        ret = mq.pop_back();
      end
      if (cs_jsr_h) model_push(cur + 14'd1);
      m_addr = ret;
    end else begin
      m = (cs_but_h != 6'h00) ? ubr_or_h : 6'h00;
      if (cs_jsr_h) model_push(cur + 14'd1);
      m_addr = {cs_next_h[13:6], cs_next_h[5:0] | m};
    end
  endtask

  initial begin
    // Directed sequence from reset; each row is one edge.
    tbl.push_back(mk(0,0,0,6'h00,6'h00,14'h0123, 14'h0123,0,0,0,0));
    tbl.push_back(mk(0,0,0,6'h05,6'h2A,14'h0240, 14'h026A,0,0,0,0));
    tbl.push_back(mk(0,0,0,6'h00,6'h2A,14'h0240, 14'h0240,0,0,0,0));
    tbl.push_back(mk(0,0,0,6'h00,6'h00,14'h0100, 14'h0100,0,0,0,0));
    tbl.push_back(mk(0,0,1,6'h00,6'h00,14'h0800, 14'h0800,0,1,0,0));
    tbl.push_back(mk(0,0,0,6'h01,6'h00,14'h0000, 14'h0101,0,0,0,0));
    tbl.push_back(mk(0,0,0,6'h00,6'h00,14'h0456, 14'h0456,0,0,0,0));
    tbl.push_back(mk(1,1,1,6'h05,6'h3F,14'h1234, 14'h0010,1,1,0,0));
    tbl.push_back(mk(0,0,0,6'h00,6'h00,14'h0300, 14'h0300,0,1,0,0));
    tbl.push_back(mk(0,0,0,6'h01,6'h00,14'h0000, 14'h0456,0,0,0,0));
    tbl.push_back(mk(0,0,0,6'h00,6'h00,14'h3FFF, 14'h3FFF,0,0,0,0));
    tbl.push_back(mk(0,0,1,6'h00,6'h00,14'h0200, 14'h0200,0,1,0,0));
    tbl.push_back(mk(0,0,1,6'h01,6'h00,14'h0000, 14'h0000,0,1,0,0));
    tbl.push_back(mk(0,0,0,6'h01,6'h00,14'h0000, 14'h0201,0,0,0,0));
    tbl.push_back(mk(0,0,0,6'h01,6'h00,14'h0000, 14'h0000,0,0,0,1));
    tbl.push_back(mk(0,1,0,6'h05,6'h15,14'h0555, 14'h0000,0,0,0,1));
    tbl.push_back(mk(0,0,0,6'h3F,6'h15,14'h0080, 14'h0095,0,0,0,1));
    tbl.push_back(mk(0,0,1,6'h01,6'h00,14'h0000, 14'h0000,0,1,0,1));

    drive(0,0,0,6'h00,6'h00,14'h0123);
    #1;
    chk_all("reset", 14'h0000, 0, 0, 0, 0);
    #1 init_l = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].trap, tbl[i].stall, tbl[i].jsr, tbl[i].but, tbl[i].ubr, tbl[i].nxt);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].e_addr, tbl[i].e_ack,
              tbl[i].e_depth, tbl[i].e_ovf, tbl[i].e_unf);
    end

    // Nine calls into an 8-deep stack, then unwind past the bottom.
    pulse_reset();
    drive(0,0,0,6'h00,6'h00,14'h0A00);
    tick();
    chk("ovf.start", 32'(cs_addr_h), 32'h0A00);
    for (int i = 0; i < 9; i++) begin
      drive(0,0,1,6'h00,6'h00,14'(14'h0A00 + (i + 1) * 16));
      tick();
      chk($sformatf("ovf.push%0d.depth", i), 32'(ustk_depth_h), 32'((i + 1 > 8) ? 8 : i + 1));
      chk($sformatf("ovf.push%0d.flag", i), 32'(ustk_ovf_h), 32'(i == 8));
    end
    for (int k = 8; k >= 1; k--) begin
      drive(0,0,0,6'h01,6'h00,14'h0000);
      tick();
      chk($sformatf("ovf.ret%0d.addr", k), 32'(cs_addr_h), 32'(14'h0A00 + k * 16 + 1));
      chk($sformatf("ovf.ret%0d.depth", k), 32'(ustk_depth_h), 32'(k - 1));
    end
    drive(0,0,0,6'h01,6'h00,14'h0000);
    tick();
    chk_all("unf.ret9", 14'h0000, 0, 0, 1, 1);

    // Stall holds through changing next fields; async reset clears mid-stall.
    drive(0,0,1,6'h00,6'h00,14'h0700);
    tick();
    chk_all("stall.pre", 14'h0700, 0, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      drive(0,1,1,6'h00,6'h00,14'(14'h1000 + i * 14'h111));
      tick();
      chk_all($sformatf("stall%0d", i), 14'h0700, 0, 1, 1, 1);
    end
    #2 init_l = 1'b0;
    #1;
    chk_all("async_rst", 14'h0000, 0, 0, 0, 0);
    #1 init_l = 1'b1;
    tick();
    chk_all("post_rst_stall", 14'h0000, 0, 0, 0, 0);

    // Random phase: call-heavy first half, return-heavy second half.
    pulse_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      logic [5:0]  but;
      logic [13:0] nxt;
      int          r;
      r = int'($urandom_range(0, 5));
      if (n < 300) but = (r == 0) ? 6'h01 : (r < 3) ? 6'h00 : 6'($urandom);
      else         but = (r < 3) ? 6'h01 : (r == 3) ? 6'h00 : 6'($urandom);
      nxt = ($urandom_range(0, 15) == 0) ? 14'h3FFF : 14'($urandom);
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
            (n < 300) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0),
            but, 6'($urandom), nxt);
      model_step();
      tick();
      chk_all($sformatf("rnd%0d", n), m_addr, m_ack, mq.size(), m_ovf, m_unf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usq_addr_seq.md
Name: usq_addr_seq

Overview:
- Micro-sequencer stage directly upstream of the control store.
- Each cycle it selects the next control-store address and registers it onto cs_addr_h.
- Sources: the microword's next field with branch OR-in, micro-subroutine return, or trap vector.
- Holds an N-deep micro-return stack for JSR/RETURN and trap entry.

Parameters:
- STK_DEPTH, 8: micro-return stack entries (power of 2, 2..16).
- TRAP_VEC, 14'h0010: control-store address forced on trap entry.
- RST_VEC, 14'h0000: address presented out of reset.

Ports:
- m_clk_l  in  1: the block's single clock; all state updates on its rising edge.
- init_l  in  1: reset, asynchronous, active-low.
- stall_h  in  1: hold the current address; no stack change.
- trap_req_h  in  1: microtrap request, level; sampled each edge.
- cs_next_h  in  14: next-address field of the current microword.
- cs_jsr_h  in  1: current microword is a micro-subroutine call.
- cs_but_h  in  6: branch/utility-test code of the current microword.
- ubr_or_h  in  6: branch condition bits from the condition logic.
- cs_addr_h  out  14: registered control-store address.
- trap_ack_h  out  1: one-cycle pulse, registered, on trap entry.
- ustk_depth_h  out  $clog2(STK_DEPTH)+1: current stack occupancy.
- ustk_ovf_h  out  1: sticky overflow flag.
- ustk_unf_h  out  1: sticky underflow flag.

Behaviour:
Reset:
- init_l low asynchronously forces:
  - cs_addr_h = RST_VEC
  - stack pointer = 0
  - ustk_depth_h = 0
  - trap_ack_h = 0
  - ustk_ovf_h = 0
  - ustk_unf_h = 0
- Stack contents are don't-care after reset.
- Reset asserted mid-sequence discards any pending push, pop or trap.

Next-address priority, evaluated each edge with init_l high, highest first:
1. trap_req_h:
   - Push the current cs_addr_h, the aborted microinstruction, so it is retried on return.
   - cs_addr_h <= TRAP_VEC; trap_ack_h <= 1.
   - stall_h, cs_jsr_h and cs_but_h are ignored in this cycle.
2. stall_h:
   - cs_addr_h holds; stack and flags hold; trap_ack_h <= 0.
3. cs_but_h == BUT_RET (6'h01):
   - Pop; cs_addr_h <= popped top.
   - If cs_jsr_h is also set, push (cs_addr_h + 1) in the same edge. The pop and push replace the top entry; depth is unchanged.
4. Otherwise:
   - cs_addr_h <= {cs_next_h[13:6], cs_next_h[5:0] | m}.
   - m = ubr_or_h when cs_but_h is not BUT_NONE (6'h00) and not BUT_RET; m = 6'h00 otherwise.
   - If cs_jsr_h is set, push (cs_addr_h + 1). The add is 14-bit and 14'h3FFF+1 wraps to 14'h0000.
- trap_ack_h is 0 on every edge except a trap entry.

Stack rules:
- Latency: the pushed value is readable by a RETURN on the very next edge.
- Push when full:
  - The oldest entry is overwritten; the stack is circular.
  - Depth saturates at STK_DEPTH.
  - ustk_ovf_h <= 1 (sticky until reset).
- Pop when empty:
  - cs_addr_h <= RST_VEC; depth stays 0.
  - ustk_unf_h <= 1 (sticky).
- Combined pop+push on an empty stack:
  - Underflow is flagged.
  - The push still lands; depth becomes 1.
  - cs_addr_h <= RST_VEC.
- Trap on a full stack behaves as a push-when-full overflow.

Decomposition:
- Shared package usq_pkg holds:
  - constants BUT_NONE = 6'h00, BUT_RET = 6'h01
  - default TRAP_VEC and RST_VEC
  - typedef uaddr_t = 14-bit address
- One sub-module, usq_stack:
  - circular LIFO with push/pop/replace
  - inputs: push_en, pop_en, push_data
  - outputs: top, depth, ovf/unf strobes
- The top level holds the address mux, the incrementer, the output register and the sticky flags.

Test Plan:
1. Reset then release, cs_next_h=14'h0123, cs_but_h=0 -> cs_addr_h=0000 during reset, 0123 after the first edge; all flags 0.
2. Branch OR: cs_next_h=14'h0240, cs_but_h=6'h05, ubr_or_h=6'h2A -> cs_addr_h=026A. Same inputs with cs_but_h=0 -> 0240.
3. Call/return:
   - At address 0100, cs_jsr_h=1, cs_next_h=0800 -> cs_addr_h=0800, depth=1.
   - Next, cs_but_h=BUT_RET -> cs_addr_h=0101, depth=0.
4. Trap:
   - At address 0456, trap_req_h=1 with stall_h=1 and cs_jsr_h=1 -> cs_addr_h=0010, trap_ack_h=1 for one cycle, depth=1.
   - A later RETURN -> cs_addr_h=0456.
5. Overflow:
   - 9 consecutive JSRs from addresses A0..A8 with STK_DEPTH=8 -> ustk_ovf_h=1, depth=8.
   - 8 RETURNs yield A8+1 down to A1+1.
   - A 9th RETURN -> cs_addr_h=0000, ustk_unf_h=1.
6. Stall and async reset:
   - stall_h high for 3 cycles with changing cs_next_h -> cs_addr_h holds.
   - init_l pulsed low between edges mid-stall -> cs_addr_h=0000 immediately, depth=0, flags cleared.
